// File: rtl/dsa_bilinear_core_simd.sv
// Bilinear interpolation back end: captures one SIMD burst of pixel neighbourhoods,
// interpolates each lane in two registered multiply stages, then writes lanes serially.
module dsa_bilinear_core_simd #(
   parameter int ADDR_WIDTH    = 20,
   parameter int OUT_IMG_WIDTH = 1024,
   parameter int SIMD_WIDTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fetch_valid,
   input  logic [8*SIMD_WIDTH-1:0] p00,
   input  logic [8*SIMD_WIDTH-1:0] p01,
   input  logic [8*SIMD_WIDTH-1:0] p10,
   input  logic [8*SIMD_WIDTH-1:0] p11,
   input  logic [16*SIMD_WIDTH-1:0] a,
   input  logic [16*SIMD_WIDTH-1:0] b,
   input  logic [15:0]             out_x,
   input  logic [15:0]             out_y,
   input  logic [2:0]              valid_lanes,
   input  logic [ADDR_WIDTH-1:0]   dst_base_addr,
   input  logic                    clr_err,
   output logic                    in_ready,
   output logic                    mem_write_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [7:0]              mem_wdata,
   output logic                    done,
   output logic                    busy,
   output logic                    overrun_err
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HORIZ = 3'd1;
   localparam logic [2:0] ST_VERT  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Handshake: a burst is taken only when fetch_valid is high while in_ready is high;
   // any other fetch_valid pulse is dropped and flagged in overrun_err.
   logic [2:0]            state;
   logic [2:0]            lane_idx;
   logic [2:0]            cap_n;
   logic [15:0]           cap_x;
   logic [15:0]           cap_y;
   logic [ADDR_WIDTH-1:0] cap_base;
   logic [7:0]            cap_p00 [SIMD_WIDTH];
   logic [7:0]            cap_p01 [SIMD_WIDTH];
   logic [7:0]            cap_p10 [SIMD_WIDTH];
   logic [7:0]            cap_p11 [SIMD_WIDTH];
   logic [7:0]            cap_a   [SIMD_WIDTH];
   logic [7:0]            cap_b   [SIMD_WIDTH];
   logic [16:0]           top_r   [SIMD_WIDTH];
   logic [16:0]           bot_r   [SIMD_WIDTH];
   logic [7:0]            res_r   [SIMD_WIDTH];
   logic [16:0]           top_c   [SIMD_WIDTH];
   logic [16:0]           bot_c   [SIMD_WIDTH];
   logic [24:0]           rnd_c   [SIMD_WIDTH];
   logic [8:0]            hi_c    [SIMD_WIDTH];
   logic [7:0]            res_c   [SIMD_WIDTH];
   logic [2:0]            lanes_clamped;
   logic [7:0]            wdata_sel;
   logic                  unused_frac_hi;

   // Only the low byte of each fraction lane carries weight.
   assign unused_frac_hi = ^{a, b};

   assign lanes_clamped = (valid_lanes > 3'(SIMD_WIDTH)) ? 3'(SIMD_WIDTH) : valid_lanes;

   always_comb begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
         top_c[i] = {9'd0, cap_p00[i]} * (17'd256 - {9'd0, cap_a[i]})
                  + {9'd0, cap_p01[i]} * {9'd0, cap_a[i]};
         bot_c[i] = {9'd0, cap_p10[i]} * (17'd256 - {9'd0, cap_a[i]})
                  + {9'd0, cap_p11[i]} * {9'd0, cap_a[i]};
         rnd_c[i] = {8'd0, top_r[i]} * (25'd256 - {17'd0, cap_b[i]})
                  + {8'd0, bot_r[i]} * {17'd0, cap_b[i]} + 25'd32768;
         hi_c[i]  = 9'(rnd_c[i] >> 16);
         res_c[i] = (hi_c[i] > 9'd255) ? 8'd255 : hi_c[i][7:0];
      end
   end

   always_comb begin
      wdata_sel = 8'd0;
      for (int i = 0; i < SIMD_WIDTH; i++) begin
         if (lane_idx == 3'(i)) wdata_sel = res_r[i];
      end
   end

   assign in_ready     = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_DONE);
   assign mem_write_en = (state == ST_WRITE);
   assign mem_wdata    = mem_write_en ? wdata_sel : 8'd0;
   assign mem_addr     = mem_write_en
                       ? (cap_base + ADDR_WIDTH'(cap_y) * ADDR_WIDTH'(OUT_IMG_WIDTH)
                          + ADDR_WIDTH'(cap_x) + ADDR_WIDTH'(lane_idx))
                       : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         lane_idx <= 3'd0;
         cap_n    <= 3'd0;
         cap_x    <= 16'd0;
         cap_y    <= 16'd0;
         cap_base <= '0;
         for (int i = 0; i < SIMD_WIDTH; i++) begin
            cap_p00[i] <= 8'd0;
            cap_p01[i] <= 8'd0;
            cap_p10[i] <= 8'd0;
            cap_p11[i] <= 8'd0;
            cap_a[i]   <= 8'd0;
            cap_b[i]   <= 8'd0;
            top_r[i]   <= 17'd0;
            bot_r[i]   <= 17'd0;
            res_r[i]   <= 8'd0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (fetch_valid) begin
                  for (int i = 0; i < SIMD_WIDTH; i++) begin
                     cap_p00[i] <= p00[8*i +: 8];
                     cap_p01[i] <= p01[8*i +: 8];
                     cap_p10[i] <= p10[8*i +: 8];
                     cap_p11[i] <= p11[8*i +: 8];
                     cap_a[i]   <= a[16*i +: 8];
                     cap_b[i]   <= b[16*i +: 8];
                  end
                  cap_x    <= out_x;
                  cap_y    <= out_y;
                  cap_base <= dst_base_addr;
                  cap_n    <= lanes_clamped;
                  state    <= ST_HORIZ;
               end
            end
            ST_HORIZ: begin
               for (int i = 0; i < SIMD_WIDTH; i++) begin
                  top_r[i] <= top_c[i];
                  bot_r[i] <= bot_c[i];
               end
               state <= ST_VERT;
            end
            ST_VERT: begin
               for (int i = 0; i < SIMD_WIDTH; i++) res_r[i] <= res_c[i];
               lane_idx <= 3'd0;
               state    <= (cap_n == 3'd0) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
               if (lane_idx == cap_n - 3'd1) state <= ST_DONE;
               else lane_idx <= lane_idx + 3'd1;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // A dropped pulse beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun_err <= 1'b0;
      else if (fetch_valid && state != ST_IDLE) overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
   end

endmodule
